// File: rtl/adc_axis_packer_pkg.sv
// Shared constants and beat-entry type for the ADC-to-AXI-Stream packer.
package adc_axis_pkg;

  localparam int DEF_LANE_WIDTH  = 16;
  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_FRAME_BEATS = 256;

  typedef struct packed {
    logic [DEF_TDATA_WIDTH-1:0] tdata;
    logic                       tlast;
  } beat_t;

  // Counter width that stays legal (>= 1 bit) for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_axis_packer_if.sv
// AXI-Stream beat bundle between the packer's output FIFO and its consumer.
interface adc_axis_packer_if
  import adc_axis_pkg::*;
#(
  parameter int DATA_W = DEF_TDATA_WIDTH
) ();

  // A beat moves on every rising edge where tvalid && tready; once tvalid is
  // raised, tdata/tlast stay frozen until that transfer happens.
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/adc_axis_packer_fifo.sv
// axis_sync_fifo: single-clock beat FIFO with simultaneous push/pop.
// Per-entry tlast storage exists only when ADC_AXIS_PACKER_TLAST_EN is defined.
module axis_sync_fifo
  import adc_axis_pkg::*;
#(
  parameter int DATA_W = DEF_TDATA_WIDTH,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef ADC_AXIS_PACKER_TLAST_EN
  input  logic              wlast_i,
`endif
  output logic              full_o,
  adc_axis_packer_if.master m_o
);

`ifdef ADC_AXIS_PACKER_TLAST_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif
  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("axis_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [ENT_W-1:0] wentry, head;
  logic             empty, pop, do_push;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && m_o.tready;
  assign do_push = push_i && (!full_o || pop);
  assign head    = mem_q[rd_q[AW-1:0]];

`ifdef ADC_AXIS_PACKER_TLAST_EN
  assign wentry    = {wlast_i, wdata_i};
  assign m_o.tlast = !empty && head[DATA_W];
`else
  assign wentry    = wdata_i;
  assign m_o.tlast = 1'b0;
`endif
  assign m_o.tvalid = !empty;
  assign m_o.tdata  = empty ? '0 : head[DATA_W-1:0];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (pop)     rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wentry;
  end

endmodule

// File: rtl/adc_axis_packer.sv
// adc_axis_packer: packs ADC samples into lanes of AXI-Stream beats, buffered by
// a FIFO that drops whole beats when full. ADC_AXIS_PACKER_TLAST_EN adds framing.
module adc_axis_packer
  import adc_axis_pkg::*;
#(
  parameter int ADC_WIDTH        = 16,
  parameter int AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int LANE_WIDTH       = DEF_LANE_WIDTH,
  parameter int SIGNED           = 0,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
  parameter int FRAME_BEATS      = DEF_FRAME_BEATS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADC_WIDTH-1:0]        adc_data_in,
  input  logic                        adc_data_valid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        M_AXIS_OUT_tlast,
  output logic                        overflow,
  input  logic                        overflow_clr
);

  localparam int SPB = AXIS_TDATA_WIDTH / LANE_WIDTH;
  localparam int LW  = cnt_width(SPB);

  if ((ADC_WIDTH < 1) || (ADC_WIDTH > LANE_WIDTH) || (SPB < 1) ||
      ((AXIS_TDATA_WIDTH % LANE_WIDTH) != 0) || (FRAME_BEATS < 1)) begin : g_param_check
    $error("adc_axis_packer: inconsistent width or frame parameters");
  end

  logic [LW-1:0]               lane_q, lane_d;
  logic [AXIS_TDATA_WIDTH-1:0] partial_q, partial_d, beat_data;
  logic signed [ADC_WIDTH-1:0] sample_s;
  logic [LANE_WIDTH-1:0]       lane_val;
  logic                        overflow_q, overflow_d;
  logic                        complete, push, drop, pop, fifo_full;

  adc_axis_packer_if #(.DATA_W(AXIS_TDATA_WIDTH)) m_axis ();

  assign sample_s = adc_data_in;

  always_comb begin
    if (SIGNED != 0) lane_val = LANE_WIDTH'(sample_s);
    else             lane_val = LANE_WIDTH'(adc_data_in);
  end

  // The finishing sample is merged combinationally so the full beat is pushed
  // in the same cycle it arrives.
  always_comb begin
    beat_data = partial_q;
    beat_data[lane_q*LANE_WIDTH +: LANE_WIDTH] = lane_val;
  end

  assign complete = adc_data_valid && (lane_q == LW'(SPB - 1));
  assign pop      = m_axis.tvalid && m_axis.tready;
  assign push     = complete && (!fifo_full || pop);
  assign drop     = complete && fifo_full && !pop;

  always_comb begin
    lane_d     = lane_q;
    partial_d  = partial_q;
    overflow_d = overflow_q;
    if (adc_data_valid) begin
      partial_d = beat_data;
      lane_d    = complete ? '0 : lane_q + 1'b1;
    end
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q     <= '0;
      partial_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      partial_q  <= partial_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ADC_AXIS_PACKER_TLAST_EN
  localparam int FW = cnt_width(FRAME_BEATS);
  logic [FW-1:0] frame_q, frame_d;
  logic          beat_last;

  // Only beats that actually enter the FIFO advance the frame position.
  assign beat_last = (frame_q == FW'(FRAME_BEATS - 1));

  always_comb begin
    frame_d = frame_q;
    if (push) frame_d = beat_last ? '0 : frame_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_q <= '0;
    else     frame_q <= frame_d;
  end
`endif

  axis_sync_fifo #(
    .DATA_W (AXIS_TDATA_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (beat_data),
`ifdef ADC_AXIS_PACKER_TLAST_EN
    .wlast_i (beat_last),
`endif
    .full_o  (fifo_full),
    .m_o     (m_axis)
  );

  assign m_axis.tready     = M_AXIS_OUT_tready;
  assign M_AXIS_OUT_tdata  = m_axis.tdata;
  assign M_AXIS_OUT_tvalid = m_axis.tvalid;
  assign M_AXIS_OUT_tlast  = m_axis.tlast;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Bench for adc_axis_packer: directed scenarios plus random traffic against a
// queue-based reference; a second instance covers signed 12-bit samples.
module tb_adc_axis_packer;
  import adc_axis_pkg::*;

  localparam int DW    = 32;
  localparam int SPB   = 2;
  localparam int DEPTH = 8;
  localparam int FB    = 4;
  localparam int W     = $bits(beat_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        ovf;
  logic        ovf_clr;

  adc_axis_packer_if #(.DATA_W(DW)) mon ();

  adc_axis_packer #(.FRAME_BEATS(FB)) dut (
    .clk               (clk),
    .rst               (rst),
    .adc_data_in       (adc_data),
    .adc_data_valid    (adc_valid),
    .M_AXIS_OUT_tdata  (mon.tdata),
    .M_AXIS_OUT_tvalid (mon.tvalid),
    .M_AXIS_OUT_tready (mon.tready),
    .M_AXIS_OUT_tlast  (mon.tlast),
    .overflow          (ovf),
    .overflow_clr      (ovf_clr)
  );

  logic [11:0] s_data;
  logic        s_valid;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        s_ovf;
  logic        s_clr;

  adc_axis_packer #(.ADC_WIDTH(12), .SIGNED(1)) dut_s (
    .clk               (clk),
    .rst               (rst),
    .adc_data_in       (s_data),
    .adc_data_valid    (s_valid),
    .M_AXIS_OUT_tdata  (s_tdata),
    .M_AXIS_OUT_tvalid (s_tvalid),
    .M_AXIS_OUT_tready (s_tready),
    .M_AXIS_OUT_tlast  (s_tlast),
    .overflow          (s_ovf),
    .overflow_clr      (s_clr)
  );

  // ---------------- scoreboard / reference ----------------
  int total = 0;
  int bad   = 0;
  int tlast_seen = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  pend_q[$];
  int           m_frame;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sx12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    m_frame = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock of the reference: beats leave on tvalid&&tready, a beat is
  // formed every SPB samples and is kept unless the queue is full with no
  // departure this cycle.
  task automatic model_step(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
    logic        pop, full, dropped;
    logic [31:0] word;
    beat_t       b;
    pop     = (exp_q.size() != 0) && rdy;
    full    = (exp_q.size() == DEPTH);
    dropped = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (v) begin
      pend_q.push_back(d);
      if (pend_q.size() == SPB) begin
        word = '0;
        for (int i = 0; i < SPB; i++) word = word | (32'(pend_q[i]) << (16 * i));
        pend_q.delete();
        if (!full || pop) begin
          b.tdata = word;
`ifdef ADC_AXIS_PACKER_TLAST_EN
          b.tlast = (m_frame == FB - 1);
`else
          b.tlast = 1'b0;
`endif
          m_frame = (m_frame + 1) % FB;
          exp_q.push_back(W'(b));
        end else begin
          dropped = 1'b1;
        end
      end
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
    beat_t hb;
    @(negedge clk);
    chk("tvalid", mon.tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      hb = beat_t'(exp_q[0]);
      chk("tdata", mon.tdata, hb.tdata);
      chk("tlast", mon.tlast, hb.tlast);
    end
    chk("overflow", ovf, m_ovf);
    adc_valid  = v;
    adc_data   = d;
    mon.tready = rdy;
    ovf_clr    = clr;
    if (mon.tvalid && mon.tlast && rdy) tlast_seen++;
    model_step(v, d, rdy, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    adc_valid  = 1'b0;
    adc_data   = '0;
    mon.tready = 1'b0;
    ovf_clr    = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_tvalid", mon.tvalid, 1'b0);
    chk("rst_tdata", mon.tdata, 32'h0);
    chk("rst_tlast", mon.tlast, 1'b0);
    chk("rst_overflow", ovf, 1'b0);
    chk("rst_s_tvalid", s_tvalid, 1'b0);
    model_clear();
  endtask

  task automatic s_cycle(input logic v, input logic [11:0] d);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [11:0] sa, sb;
    logic        rdy;
    rst = 1'b1; adc_valid = 1'b0; adc_data = '0; mon.tready = 1'b0; ovf_clr = 1'b0;
    s_valid = 1'b0; s_data = '0; s_tready = 1'b1; s_clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);

    // Two samples form one beat, visible one clock after the second.
    do_reset();
    cycle(1'b1, 16'h0001, 1'b1, 1'b0);
    cycle(1'b1, 16'h0002, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("basic_tdata", mon.tdata, 32'h0002_0001);
    chk("basic_tvalid", mon.tvalid, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // Blocked output: 9 beats into 8 entries, then clear and drain.
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_head", mon.tdata, 32'h0101_0100);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ovf_cleared", ovf, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("drain_empty", mon.tvalid, 1'b0);

    // Full FIFO with a pop on the completing cycle keeps the beat.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h0211, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("full_pop_no_ovf", ovf, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // Framing: 16 samples = 8 beats, tlast on beats 3 and 7 when enabled.
    do_reset();
    tlast_seen = 0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef ADC_AXIS_PACKER_TLAST_EN
    chk("tlast_count", tlast_seen, 2);
`else
    chk("tlast_count", tlast_seen, 0);
`endif

    // Reset after a lone sample discards it.
    do_reset();
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
    cycle(1'b1, 16'hBBBB, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("rst_mid_beat", mon.tdata, 32'hBBBB_AAAA);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic with a long stall window to provoke drops.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy = (i >= 120 && i < 200) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 9) < 7, 16'($urandom), rdy, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("rand_drained", mon.tvalid, 1'b0);

    // Signed 12-bit instance.
    do_reset();
    s_cycle(1'b1, 12'h800);
    s_cycle(1'b1, 12'h7FF);
    @(negedge clk);
    s_valid = 1'b0;
    chk("signed_tvalid", s_tvalid, 1'b1);
    chk("signed_tdata", s_tdata, 32'h07FF_F800);
    for (int i = 0; i < 4; i++) begin
      sa = 12'($urandom);
      sb = 12'($urandom);
      s_cycle(1'b1, sa);
      s_cycle(1'b1, sb);
      @(negedge clk);
      s_valid = 1'b0;
      chk("signed_rand", s_tdata, {sx12(sb), sx12(sa)});
    end
    chk("signed_ovf", s_ovf, 1'b0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
